// File: rtl/watchdog_pkg.sv
// Shared types and constants for the eig_core result framer.
package watchdog_pkg;

    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
    localparam int unsigned FRAME_LEN     = 11;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        HDR,
        DATA,
        CSUM
    } frame_state_e;

    typedef struct packed {
        logic [2:0]  regime;
        logic [31:0] kappa;
        logic [31:0] inv_kappa;
    } result_t;

    // Payload byte idx (0..7): kappa bytes 3..0 followed by inv_kappa bytes 3..0.
    function automatic logic [7:0] result_byte(input result_t r, input logic [2:0] idx);
        logic [63:0] words;
        words = {r.kappa, r.inv_kappa};
        return words[8*(7 - int'(idx)) +: 8];
    endfunction

endpackage

// File: rtl/result_framer_if.sv
// Result input, byte stream output and status signals of the result framer.
interface result_framer_if;

    logic        res_valid;
    logic [2:0]  regime;
    logic [31:0] kappa;
    logic [31:0] inv_kappa;
    logic        tx_ready;
    logic        clr_ovf;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    logic        overflow;

    modport master (
        output res_valid, regime, kappa, inv_kappa, tx_ready, clr_ovf,
        input  tx_data, tx_valid, busy, overflow
    );

    modport slave (
        input  res_valid, regime, kappa, inv_kappa, tx_ready, clr_ovf,
        output tx_data, tx_valid, busy, overflow
    );

endinterface

// File: rtl/result_framer_slot.sv
// Single-entry holding register for a result waiting behind the frame in flight.
module result_slot
    import watchdog_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    load,
    input  logic    drain,
    input  result_t load_data,
    output logic    valid,
    output result_t data
);

    logic    valid_q, valid_d;
    result_t data_q, data_d;

    // Load overrides drain so a same-cycle drain+load leaves the slot full with the new entry.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    // Slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/result_framer.sv
// Serialises eig_core results into 11-byte frames on a valid/ready byte stream.
module result_framer
    import watchdog_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    result_framer_if.slave bus
);

    localparam int unsigned DATA_LEN = FRAME_LEN - 3;
    localparam logic [2:0]  LAST_IDX = 3'(DATA_LEN - 1);

    frame_state_e state_q, state_d;
    logic [2:0]   idx_q, idx_d;
    result_t      active_q, active_d;
    logic [4:0]   hdr_seq_q, hdr_seq_d;
    logic [4:0]   seq_q, seq_d;
    logic [7:0]   last_q, last_d;
    logic         overflow_q, overflow_d;
    logic         first_q, first_d;
    logic         rv_q, rv_d;

    result_t      in_res;
    result_t      slot_data;
    result_t      start_res;
    logic         slot_valid, slot_load, slot_drain;
    logic         accept, xfer, start, start_from_input, drop;
    logic [7:0]   hdr_byte, csum_byte, cur_byte;

    assign in_res = '{bus.regime, bus.kappa, bus.inv_kappa};

    // A res_valid that was already high during reset is not a new pulse on the first cycle out.
    assign accept = bus.res_valid && !(first_q && rv_q);
    assign xfer   = (state_q != IDLE) && bus.tx_ready;

    result_slot u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (slot_load),
        .drain     (slot_drain),
        .load_data (in_res),
        .valid     (slot_valid),
        .data      (slot_data)
    );

    // Byte presented for the current state; IDLE re-presents the last byte.
    always_comb begin
        hdr_byte  = {hdr_seq_q, active_q.regime};
        csum_byte = hdr_byte;
        for (int unsigned i = 0; i < DATA_LEN; i++) begin
            csum_byte = csum_byte ^ result_byte(active_q, 3'(i));
        end
        cur_byte = last_q;
        case (state_q)
            SYNC:    cur_byte = SYNC_BYTE;
            HDR:     cur_byte = hdr_byte;
            DATA:    cur_byte = result_byte(active_q, idx_q);
            CSUM:    cur_byte = csum_byte;
            default: cur_byte = last_q;
        endcase
    end

    // Next-state, frame start, pending-slot and overflow control.
    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        active_d         = active_q;
        hdr_seq_d        = hdr_seq_q;
        seq_d            = seq_q;
        last_d           = cur_byte;
        overflow_d       = overflow_q;
        first_d          = 1'b0;
        rv_d             = bus.res_valid;
        slot_load        = 1'b0;
        slot_drain       = 1'b0;
        start            = 1'b0;
        start_from_input = 1'b0;
        start_res        = in_res;
        drop             = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    start            = 1'b1;
                    start_from_input = 1'b1;
                end
            end
            SYNC: begin
                if (xfer) state_d = HDR;
            end
            HDR: begin
                if (xfer) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (xfer) begin
                    if (idx_q == LAST_IDX) state_d = CSUM;
                    else                   idx_d   = idx_q + 3'd1;
                end
            end
            CSUM: begin
                if (xfer) begin
                    // Pending result goes first; a result arriving now with the slot empty starts directly.
                    if (slot_valid) begin
                        start      = 1'b1;
                        start_res  = slot_data;
                        slot_drain = 1'b1;
                    end else if (accept) begin
                        start            = 1'b1;
                        start_from_input = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            state_d   = SYNC;
            active_d  = start_res;
            hdr_seq_d = seq_q;
            seq_d     = seq_q + 5'd1;
        end

        if (accept && !start_from_input) begin
            if (!slot_valid || slot_drain) slot_load = 1'b1;
            else                           drop      = 1'b1;
        end

        if (bus.clr_ovf) overflow_d = 1'b0;
        if (drop)        overflow_d = 1'b1;
    end

    // Frame state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            active_q   <= '0;
            hdr_seq_q  <= '0;
            seq_q      <= '0;
            last_q     <= '0;
            overflow_q <= 1'b0;
            first_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            active_q   <= active_d;
            hdr_seq_q  <= hdr_seq_d;
            seq_q      <= seq_d;
            last_q     <= last_d;
            overflow_q <= overflow_d;
            first_q    <= first_d;
        end
    end

    // res_valid history keeps sampling through reset so a held pulse can be recognised afterwards.
    always_ff @(posedge clk) begin
        rv_q <= rv_d;
    end

    assign bus.tx_data  = cur_byte;
    assign bus.tx_valid = (state_q != IDLE);
    assign bus.busy     = (state_q != IDLE) || slot_valid;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_result_framer.sv
// Directed bench for result_framer with a byte-stream reference model.
module tb_result_framer;

    localparam int unsigned FL = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    result_framer_if bus ();

    result_framer #(.SYNC_BYTE(8'hA5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    // Reference frame built directly from the frame layout.
    function automatic void build_frame(input logic [2:0] r, input logic [31:0] k, input logic [31:0] ik,
                                        input logic [4:0] s, output logic [7:0] f [FL]);
        f[0] = 8'hA5;
        f[1] = {s, r};
        for (int j = 0; j < 4; j++) begin
            f[2 + j] = 8'(k  >> (8 * (3 - j)));
            f[6 + j] = 8'(ik >> (8 * (3 - j)));
        end
        f[10] = 8'h00;
        for (int j = 1; j <= 9; j++) f[10] = f[10] ^ f[j];
    endfunction

    // Model: the outstanding byte stream; a result is dropped when a whole frame is already waiting.
    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];
    logic [7:0]  mf [FL];
    logic        ovf_m  = 1'b0;
    logic [4:0]  seq_m  = '0;
    logic [7:0]  last_m = '0;
    logic        rst_prev_m = 1'b1;
    logic        rv_prev_m  = 1'b0;
    logic        acc_m;

    always @(negedge rst_n) begin
        exp_q.delete();
        ovf_m  = 1'b0;
        seq_m  = '0;
        last_m = '0;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            ovf_m      = 1'b0;
            seq_m      = '0;
            last_m     = '0;
            rst_prev_m = 1'b1;
        end else begin
            if (exp_q.size() != 0 && bus.tx_ready) last_m = exp_q.pop_front();
            acc_m = bus.res_valid && !(rst_prev_m && rv_prev_m);
            if (bus.clr_ovf) ovf_m = 1'b0;
            if (acc_m) begin
                if (exp_q.size() > FL) begin
                    ovf_m = 1'b1;
                end else begin
                    build_frame(bus.regime, bus.kappa, bus.inv_kappa, seq_m, mf);
                    for (int j = 0; j < FL; j++) exp_q.push_back(mf[j]);
                    seq_m = seq_m + 5'd1;
                end
            end
            rst_prev_m = 1'b0;
        end
        rv_prev_m = bus.res_valid;
    end

    // Per-cycle comparison of all outputs against the model.
    logic       hold_m = 1'b0;
    logic [7:0] held_m = '0;
    logic       v_m;

    always @(negedge clk) begin
        v_m = (exp_q.size() != 0);
        chk("tx_valid", 64'(bus.tx_valid), 64'(v_m));
        chk("busy",     64'(bus.busy),     64'(v_m));
        chk("overflow", 64'(bus.overflow), 64'(ovf_m));
        chk("tx_data",  64'(bus.tx_data),  64'(v_m ? exp_q[0] : last_m));
        if (hold_m && rst_n) chk("tx_data_hold", 64'(bus.tx_data), 64'(held_m));
        hold_m = v_m && !bus.tx_ready && rst_n;
        held_m = bus.tx_data;
        if (bus.tx_valid && bus.tx_ready) got_q.push_back(bus.tx_data);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [2:0] r, input logic [31:0] k, input logic [31:0] ik);
        bus.res_valid = 1'b1;
        bus.regime    = r;
        bus.kappa     = k;
        bus.inv_kappa = ik;
        tick();
        bus.res_valid = 1'b0;
        bus.regime    = 3'($urandom);
        bus.kappa     = $urandom;
        bus.inv_kappa = $urandom;
    endtask

    task automatic wait_idle(input int unsigned bound);
        for (int unsigned i = 0; i < bound; i++) begin
            if (!bus.busy) break;
            tick();
        end
        chk("idle_wait", 64'(bus.busy), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        got_q.delete();
    endtask

    logic [7:0] lit1 [FL];

    initial begin
        lit1 = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02};
        bus.res_valid = 1'b0;
        bus.regime    = '0;
        bus.kappa     = '0;
        bus.inv_kappa = '0;
        bus.tx_ready  = 1'b1;
        bus.clr_ovf   = 1'b0;

        // Model pinned against the hand-computed frame.
        build_frame(3'd2, 32'h0001_0000, 32'h0001_0000, 5'd0, mf);
        for (int j = 0; j < FL; j++) chk("model_frame", 64'(mf[j]), 64'(lit1[j]));

        tick();
        chk("reset_tx_data", 64'(bus.tx_data), 64'h00);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        do_reset();

        // Basic frame at full rate.
        send(3'd2, 32'h0001_0000, 32'h0001_0000);
        chk("first_byte_latency", 64'(bus.tx_valid), 64'd1);
        wait_idle(40);
        chk("frame1_len", 64'(got_q.size()), 64'd11);
        for (int j = 0; j < FL; j++) chk("frame1_byte", 64'(got_q[j]), 64'(lit1[j]));

        // Same frame with tx_ready toggling.
        do_reset();
        bus.tx_ready = 1'b0;
        send(3'd2, 32'h0001_0000, 32'h0001_0000);
        for (int unsigned i = 0; i < 60; i++) begin
            if (!bus.busy) break;
            bus.tx_ready = ~bus.tx_ready;
            tick();
        end
        bus.tx_ready = 1'b1;
        wait_idle(10);
        chk("frame2_len", 64'(got_q.size()), 64'd11);
        for (int j = 0; j < FL; j++) chk("frame2_byte", 64'(got_q[j]), 64'(lit1[j]));

        // Three pulses two cycles apart: third dropped.
        do_reset();
        send(3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
        tick();
        send(3'd3, 32'hCAFE_F00D, 32'h0BAD_BEEF);
        tick();
        send(3'd3, 32'h1111_1111, 32'h2222_2222);
        chk("ovf_set", 64'(bus.overflow), 64'd1);
        wait_idle(60);
        chk("b2b_len", 64'(got_q.size()), 64'd22);
        chk("b2b_hdr0", 64'(got_q[1]), 64'h03);
        chk("b2b_sync1", 64'(got_q[11]), 64'hA5);
        chk("b2b_hdr1", 64'(got_q[12]), 64'h0B);
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        chk("ovf_clr", 64'(bus.overflow), 64'd0);

        // Sequence counter wrap over 33 frames.
        do_reset();
        for (int i = 0; i < 33; i++) begin
            got_q.delete();
            send(3'(i), $urandom, $urandom);
            wait_idle(40);
            chk("seq_hdr", 64'(got_q[1]), 64'({5'(i), 3'(i)}));
        end

        // Reset during DATA index 3.
        do_reset();
        send(3'd5, 32'hDEAD_BEEF, 32'h0123_4567);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_busy", 64'(bus.busy), 64'd0);
        got_q.delete();
        send(3'd6, 32'h0000_00FF, 32'hFF00_0000);
        wait_idle(40);
        chk("rst_seq_hdr", 64'(got_q[1]), 64'h06);

        // Result arriving on the checksum transfer with the slot full.
        do_reset();
        send(3'd1, 32'hA0A1_A2A3, 32'hA4A5_A6A7);
        tick();
        send(3'd2, 32'hB0B1_B2B3, 32'hB4B5_B6B7);
        repeat (8) tick();
        chk("csum_presented", 64'(bus.tx_data), 64'h01 ^ 64'hA0 ^ 64'hA1 ^ 64'hA2 ^ 64'hA3
                                                ^ 64'hA4 ^ 64'hA5 ^ 64'hA6 ^ 64'hA7);
        send(3'd4, 32'hC0C1_C2C3, 32'hC4C5_C6C7);
        chk("csum_no_ovf", 64'(bus.overflow), 64'd0);
        wait_idle(60);
        chk("csum_len", 64'(got_q.size()), 64'd33);
        chk("csum_hdr0", 64'(got_q[1]), 64'h01);
        chk("csum_hdr1", 64'(got_q[12]), 64'h0A);
        chk("csum_hdr2", 64'(got_q[23]), 64'h14);

        // res_valid held through reset release is ignored; a fresh pulse is accepted.
        rst_n = 1'b0;
        bus.res_valid = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        bus.res_valid = 1'b0;
        tick();
        chk("held_rv_ignored", 64'(bus.busy), 64'd0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        got_q.delete();
        send(3'd7, 32'h5555_AAAA, 32'hAAAA_5555);
        chk("fresh_rv_busy", 64'(bus.busy), 64'd1);
        wait_idle(40);
        chk("fresh_rv_hdr", 64'(got_q[1]), 64'h07);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/result_framer.md
RESULT_FRAMER -- requirements
Module: result_framer

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, the first byte of every frame.
REQ-002 SHALL have port clk  input  1  single system clock; all logic samples on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port res_valid  input  1  one-cycle pulse marking a new eig_core result.
REQ-005 SHALL have port regime  input  3  eig_core regime code, sampled with res_valid.
REQ-006 SHALL have port kappa  input  32  signed kappa word, sampled with res_valid.
REQ-007 SHALL have port inv_kappa  input  32  signed inverse-kappa word, sampled with res_valid.
REQ-008 SHALL have port tx_ready  input  1  consumer accepts the current byte.
REQ-009 SHALL have port clr_ovf  input  1  clears the overflow flag.
REQ-010 SHALL have port tx_data  output  8  current frame byte.
REQ-011 SHALL have port tx_valid  output  1  tx_data is valid.
REQ-012 SHALL have port busy  output  1  frame in progress or result pending.
REQ-013 SHALL have port overflow  output  1  sticky flag: a result was dropped.

Function
REQ-014 SHALL emit an 11-byte frame: SYNC_BYTE; header {seq[4:0], regime[2:0]}; kappa bytes 3..0, MSB first; inv_kappa bytes 3..0, MSB first; checksum.
REQ-015 SHALL compute the checksum as the XOR of bytes 1 through 9.
REQ-016 SHALL transfer a byte only on a cycle where tx_valid=1 and tx_ready=1.
REQ-017 SHALL hold tx_data stable while tx_valid=1 and tx_ready=0.
REQ-018 SHALL use FSM states IDLE, SYNC, HDR, DATA (8-byte index 0..7), CSUM.
REQ-019 SHALL use these transitions: IDLE->SYNC on a captured result; SYNC->HDR, HDR->DATA, DATA->CSUM after index 7, each on a transfer.
REQ-020 SHALL, on the CSUM transfer, go to SYNC if a result is pending, else to IDLE.
REQ-021 SHALL, when res_valid is seen in IDLE with the slot empty, capture the result into the active register and assert tx_valid with SYNC_BYTE on the next cycle (1-cycle latency).
REQ-022 SHALL, when res_valid is seen while a frame is active, store the result in a single pending slot if that slot is empty.
REQ-023 SHALL, when res_valid is seen with the pending slot full and not draining that cycle, drop the new result and set overflow=1.
REQ-024 SHALL, when res_valid coincides with the CSUM transfer and the slot is full, move the slot to active and the new result to the slot, with no overflow.
REQ-025 SHALL load seq into the header at frame start, increment seq by 1 per frame started, and wrap it from 31 to 0.
REQ-026 SHALL latch frame contents at frame start, so input changes mid-frame do not affect the frame in flight.
REQ-027 SHALL drive busy=1 when the state is not IDLE or the pending slot is valid.
REQ-028 SHALL clear overflow on clr_ovf=1; if clr_ovf and a drop occur in the same cycle, the drop wins (overflow stays 1).
REQ-029 SHALL drive tx_valid=0 in IDLE and hold tx_data at its last value there.

Reset
REQ-030 SHALL, while rst_n=0, force: tx_valid=0, tx_data=8'h00, busy=0, overflow=0, seq=0, state=IDLE, pending slot empty.
REQ-031 SHALL, on reset mid-frame, abandon the frame immediately, with no partial completion after release.
REQ-032 SHALL ignore any res_valid present in the first cycle after rst_n deasserts only if it was asserted during reset; a fresh pulse is accepted.

Structure
REQ-033 SHALL take from the shared package watchdog_pkg: SYNC_BYTE default, FRAME_LEN=11, the state enum type, and result_t struct {regime[2:0], kappa[31:0], inv_kappa[31:0]}.
REQ-034 SHALL implement the pending slot as one sub-module, result_slot (1-entry register with valid/load/drain); all else stays flat.

Verification
REQ-035 SHALL verify: regime=2, kappa=32'h00010000, inv_kappa=32'h00010000, seq=0, tx_ready=1 -> bytes A5,02,00,01,00,00,00,01,00,00,02 over 11 consecutive cycles starting 1 cycle after res_valid.
REQ-036 SHALL verify: the same frame with tx_ready toggling 1/0 every cycle -> identical byte sequence, and tx_data stable whenever tx_ready=0.
REQ-037 SHALL verify: three res_valid pulses 2 cycles apart -> frames 1 and 2 sent back-to-back with seq 0 and 1; the third is dropped and overflow=1; clr_ovf -> overflow=0.
REQ-038 SHALL verify: 33 frames in sequence -> header seq field 0..31, then 0 again.
REQ-039 SHALL verify: rst_n pulled low during DATA index 3 -> tx_valid=0 in the same cycle; after release, busy=0 and the next frame starts with seq 0.
REQ-040 SHALL verify: res_valid on the CSUM-transfer cycle with the slot full -> the pending frame follows immediately, the new result follows it, and overflow stays 0.
